i2s_slave_receiver: RTL and testbench
=====================================

# i2s_slave_receiver

Receives a Philips-format I2S stereo stream clocked by an external master (bit clock and word select are inputs) and outputs one left/right sample pair per frame with a one-cycle valid strobe. It is the receiving end of the stream produced by `i2s_audio_out` and sits between board I/O pins (GPIO or header) and `lab_top`'s audio inputs. Board-level loopback of `i2s_audio_out` through this block is the reference self-test.

## Interface

- `w_sample`, 16: bits captured per channel, MSB first.
- `idle_timeout`, 1024: `clk` cycles without a `bclk` rising edge before the FSM returns to HUNT.
- `clk`  input  1  system clock.
- `rst`  input  1  synchronous, active-high reset.
- `bclk`  input  1  external I2S bit clock, asynchronous to `clk`.
- `lrclk`  input  1  external word select; 0 = left, 1 = right.
- `sdata`  input  1  external serial data.
- `left`  output  `w_sample`  last complete left sample.
- `right`  output  `w_sample`  last complete right sample.
- `valid`  output  1  one-cycle pulse when `left`/`right` update.
- `frame_error`  output  1  one-cycle pulse on short slot or timeout.

## Operation

- **Synchronizer.** `bclk`, `lrclk` and `sdata` each pass through 2 flops. `bclk` has a third flop for rising-edge detection. All synchronizer flops reset to 0.
- **Sampling.** On each detected `bclk` rising edge ("tick"), sample synchronized `ws` and `sd`. `ws_prev` holds `ws` from the previous tick.
- **WS change.** A tick where `ws != ws_prev`.
  - A slot covers the ticks from the one after a WS change through the next WS change, inclusive. This gives the one-bit I2S delay.
  - `sd` on the WS-change tick is the last bit of the ending slot.
- **Bit counter and shift register.** The counter saturates at `w_sample`; bits beyond `w_sample` are ignored, so 24/32-bit slots are truncated to their MSBs. The shift register shifts in only while the counter is below `w_sample`. Both reset to 0 on every WS-change tick, after the ending slot is evaluated.
- **Slot completeness.** A slot is complete when it has at least `w_sample` bits, counting the WS-change tick.
- **FSM states:** HUNT, LEFT, RIGHT.
  - HUNT: a WS change to 0 goes to LEFT. A change to 1 stays in HUNT.
  - LEFT: a WS change (to 1) with a complete slot loads `left_shadow` and goes to RIGHT.
  - RIGHT: a WS change (to 0) with a complete slot copies `left_shadow` to `left`, loads `right`, pulses `valid`, and goes to LEFT.
  - Short slot in LEFT or RIGHT: pulse `frame_error`, discard the frame, leave `left`/`right` unchanged. Then take the HUNT transition for the new `ws` value (0 → LEFT, 1 → HUNT).
- **Timeout.** The idle counter clears on every tick. When it reaches `idle_timeout` in LEFT or RIGHT, pulse `frame_error` and go to HUNT. In HUNT the counter saturates with no error.
- **First output after reset or HUNT.** Requires one full left slot followed by one full right slot. The partial slot in progress when HUNT is entered is never output.
- **Reset.** `rst` overrides everything, including mid-frame. It returns state to HUNT and clears `left`, `right`, `valid`, `frame_error`, the shadow register, the counters and `ws_prev`.

## Timing

- **Reset values:** `left` = 0, `right` = 0, `valid` = 0, `frame_error` = 0, state = HUNT.
- **Minimum pulse width:** `bclk` high and low must each be at least 2 `clk` periods. At 27 MHz this gives `bclk` ≤ 6.75 MHz; the 48 kHz × 32 × 2 rate of 3.072 MHz is supported.
- **Latency:**
  - Let edge E1 be the first `clk` edge at which synchronizer flop 1 captures the `bclk` rise of a WS-change tick.
  - `valid`, `left`, `right` and state update at edge E3.
  - `left`/`right` are stable from E3 until the next `valid`.
- **Alignment:** all three inputs share synchronizer depth, so `ws`/`sd` are sampled coherently with the edge.
- **Strobe width:** `valid` and `frame_error` are exactly one `clk` cycle. Both never assert in the same cycle.

## Structure

- **Package `i2s_rx_pkg`:** state enum `i2s_rx_state_t` {HUNT, LEFT, RIGHT}, the `sync_stages` = 2 constant, and a width helper for the idle counter (`$clog2(idle_timeout+1)`).
- **Sub-module `i2s_input_synchronizer`:** 3-bit 2-flop synchronizer plus a third `bclk` flop. Outputs `ws`, `sd` and a `tick` pulse.
- **Top level:** the FSM, counters and registers stay in `i2s_slave_receiver`. Target ~200 lines.

## Test plan

- **Nominal frame.** `clk` 27 MHz, `bclk` 3 MHz, 32-bit slots, left = 16'hA5C3, right = 16'h1234 → after the second full frame, `valid` pulses once per frame with `left` = A5C3 and `right` = 1234. No `frame_error`.
- **Truncation.** 24-bit slot carrying 24'h89ABCD → output 16'h89AB.
- **Short slot.** A 12-bit right slot → `frame_error` pulses once, no `valid`, and `left`/`right` hold their previous values. The next two full slots resume `valid`.
- **Timeout.** Stop `bclk` mid-left-slot for 1100 cycles → one `frame_error` at cycle 1024, state HUNT. On restart, the first `valid` follows one complete left+right frame.
- **Mid-frame reset.** Assert `rst` for 1 cycle mid-right-slot → all outputs 0 on the next cycle, no `valid` for the interrupted frame.
- **Loopback.** Connect `i2s_audio_out` (`data_in` = 16'h7FFF then 16'h8000) to this block → both channels equal the driven value within 2 frames.

Source files
------------

// File: rtl/i2s_rx_pkg.sv
// i2s_rx_pkg: shared types and constants for the I2S slave receiver.
//   i2s_rx_state_t : receiver FSM states (HUNT, LEFT, RIGHT)
//   SYNC_STAGES    : flop depth of the input synchronizer
//   idle_cnt_w()   : width needed for an idle counter saturating at a timeout
package i2s_rx_pkg;

   typedef enum logic [1:0] {
      HUNT  = 2'd0,
      LEFT  = 2'd1,
      RIGHT = 2'd2
   } i2s_rx_state_t;

   localparam int SYNC_STAGES = 2;

   function automatic int idle_cnt_w(input int timeout);
      return $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/i2s_input_synchronizer.sv
// i2s_input_synchronizer: brings bclk, lrclk and sdata into the clk domain.
//   i_clk, i_rst : system clock, synchronous active-high reset
//   i_bclk       : external bit clock (async)
//   i_lrclk      : external word select (async)
//   i_sdata      : external serial data (async)
//   o_ws, o_sd   : synchronized word select / data
//   o_tick       : one-cycle pulse on a synchronized bclk rising edge
// All three inputs share one synchronizer depth so ws/sd line up with the tick.
module i2s_input_synchronizer
   import i2s_rx_pkg::*;
(
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_bclk,
   input  logic i_lrclk,
   input  logic i_sdata,
   output logic o_ws,
   output logic o_sd,
   output logic o_tick
);

   // bit 2 = bclk, bit 1 = lrclk, bit 0 = sdata
   logic [SYNC_STAGES-1:0][2:0] r_sync;
   logic                        r_bclk_d;
   logic [2:0]                  w_last;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync   <= '0;
         r_bclk_d <= 1'b0;
      end else begin
         r_sync[0] <= {i_bclk, i_lrclk, i_sdata};
         for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
         r_bclk_d <= r_sync[SYNC_STAGES-1][2];
      end
   end

   assign w_last = r_sync[SYNC_STAGES-1];
   assign o_ws   = w_last[1];
   assign o_sd   = w_last[0];
   assign o_tick = w_last[2] & ~r_bclk_d;

endmodule

// File: rtl/i2s_slave_receiver.sv
// i2s_slave_receiver: Philips I2S stereo receiver, bclk/lrclk driven externally.
//   i_clk, i_rst     : system clock, synchronous active-high reset
//   i_bclk, i_lrclk  : external bit clock and word select (0 = left)
//   i_sdata          : external serial data, MSB first
//   o_left, o_right  : last complete sample pair
//   o_valid          : one-cycle pulse when o_left/o_right update
//   o_frame_error    : one-cycle pulse on a short slot or a bclk timeout
module i2s_slave_receiver
   import i2s_rx_pkg::*;
#(
   parameter int W_SAMPLE     = 16,
   parameter int IDLE_TIMEOUT = 1024
)(
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_bclk,
   input  logic                i_lrclk,
   input  logic                i_sdata,
   output logic [W_SAMPLE-1:0] o_left,
   output logic [W_SAMPLE-1:0] o_right,
   output logic                o_valid,
   output logic                o_frame_error
);

   localparam int CW = $clog2(W_SAMPLE + 1);
   localparam int IW = idle_cnt_w(IDLE_TIMEOUT);

   logic                w_ws, w_sd, w_tick;
   logic                w_ws_change, w_below, w_slot_full, w_idle_hit;
   logic [W_SAMPLE-1:0] w_slot_word;

   i2s_rx_state_t       r_state;
   logic                r_ws_prev;
   logic [CW-1:0]       r_bit_cnt;
   logic [W_SAMPLE-1:0] r_shift;
   logic [IW-1:0]       r_idle;
   logic [W_SAMPLE-1:0] r_left_shadow, r_left, r_right;
   logic                r_valid, r_frame_error;

   i2s_input_synchronizer u_sync (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_bclk  (i_bclk),
      .i_lrclk (i_lrclk),
      .i_sdata (i_sdata),
      .o_ws    (w_ws),
      .o_sd    (w_sd),
      .o_tick  (w_tick)
   );

   assign w_ws_change = w_tick && (w_ws != r_ws_prev);
   assign w_below     = r_bit_cnt < CW'(W_SAMPLE);
   // The WS-change tick carries the last bit of the ending slot, so the
   // evaluated word includes it and completeness counts it.
   assign w_slot_word = w_below ? {r_shift[W_SAMPLE-2:0], w_sd} : r_shift;
   assign w_slot_full = r_bit_cnt >= CW'(W_SAMPLE - 1);
   // Fires on the cycle the idle counter steps onto IDLE_TIMEOUT.
   assign w_idle_hit  = !w_tick && (r_idle == IW'(IDLE_TIMEOUT - 1));

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state       <= HUNT;
         r_ws_prev     <= 1'b0;
         r_bit_cnt     <= '0;
         r_shift       <= '0;
         r_idle        <= '0;
         r_left_shadow <= '0;
         r_left        <= '0;
         r_right       <= '0;
         r_valid       <= 1'b0;
         r_frame_error <= 1'b0;
      end else begin
         r_valid       <= 1'b0;
         r_frame_error <= 1'b0;

         if (w_tick)                             r_idle <= '0;
         else if (r_idle != IW'(IDLE_TIMEOUT))   r_idle <= r_idle + 1'b1;

         if (w_tick) begin
            r_ws_prev <= w_ws;
            if (w_ws_change) begin
               r_bit_cnt <= '0;
               r_shift   <= '0;
            end else if (w_below) begin
               r_bit_cnt <= r_bit_cnt + 1'b1;
               r_shift   <= {r_shift[W_SAMPLE-2:0], w_sd};
            end
         end

         case (r_state)
            HUNT: begin
               if (w_ws_change && !w_ws) r_state <= LEFT;
            end
            LEFT: begin
               if (w_ws_change) begin
                  if (w_slot_full) begin
                     r_left_shadow <= w_slot_word;
                     r_state       <= RIGHT;
                  end else begin
                     r_frame_error <= 1'b1;
                     r_state       <= w_ws ? HUNT : LEFT;
                  end
               end else if (w_idle_hit) begin
                  r_frame_error <= 1'b1;
                  r_state       <= HUNT;
               end
            end
            RIGHT: begin
               if (w_ws_change) begin
                  if (w_slot_full) begin
                     r_left  <= r_left_shadow;
                     r_right <= w_slot_word;
                     r_valid <= 1'b1;
                     r_state <= LEFT;
                  end else begin
                     r_frame_error <= 1'b1;
                     r_state       <= w_ws ? HUNT : LEFT;
                  end
               end else if (w_idle_hit) begin
                  r_frame_error <= 1'b1;
                  r_state       <= HUNT;
               end
            end
            default: r_state <= HUNT;
         endcase
      end
   end

   assign o_left        = r_left;
   assign o_right       = r_right;
   assign o_valid       = r_valid;
   assign o_frame_error = r_frame_error;

endmodule

// File: tb/tb_i2s_slave_receiver.sv
// Directed bench: an I2S master model drives slots with the one-bit delay;
// a monitor counts valid / frame_error pulses and latches the pair on valid.
module tb_i2s_slave_receiver;

   localparam int HALF = 45;  // bclk half period = 4.5 clk periods

   logic        clk = 1'b0, rst = 1'b1;
   logic        bclk = 1'b0, lrclk = 1'b0, sdata = 1'b0;
   logic [15:0] left, right;
   logic        valid, frame_error;

   logic        carry = 1'b0;
   int          nchk = 0, nerr = 0;
   int          vcnt = 0, ecnt = 0, both = 0;
   logic [15:0] cap_l = '0, cap_r = '0;
   int          v0, e0;

   i2s_slave_receiver #(.W_SAMPLE(16), .IDLE_TIMEOUT(1024)) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_bclk        (bclk),
      .i_lrclk       (lrclk),
      .i_sdata       (sdata),
      .o_left        (left),
      .o_right       (right),
      .o_valid       (valid),
      .o_frame_error (frame_error)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (valid) begin
         vcnt++;
         cap_l = left;
         cap_r = right;
      end
      if (frame_error) ecnt++;
      if (valid && frame_error) both++;
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Bit periods [from,to) of a slot; vec is MSB-aligned. Each period carries
   // the previous period's bit, giving the I2S one-bit delay after WS.
   task automatic slot(input logic ws, input logic [31:0] vec, input int from, input int to);
      for (int i = from; i < to; i++) begin
         lrclk = ws;
         sdata = carry;
         carry = vec[31-i];
         #HALF bclk = 1'b1;
         #HALF bclk = 1'b0;
      end
   endtask

   task automatic mark();
      v0 = vcnt;
      e0 = ecnt;
   endtask

   initial begin
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("rst_left",  32'(left),        32'h0);
      chk("rst_right", 32'(right),       32'h0);
      chk("rst_valid", 32'(valid),       32'h0);
      chk("rst_ferr",  32'(frame_error), 32'h0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // nominal 32-bit frames
      mark();
      slot(1'b1, 32'hDEAD_BEEF, 0, 32);
      for (int f = 0; f < 3; f++) begin
         slot(1'b0, {16'hA5C3, 16'h0}, 0, 32);
         slot(1'b1, {16'h1234, 16'h0}, 0, 32);
      end
      slot(1'b0, {24'h89ABCD, 8'h0}, 0, 1);
      #50;
      chk("nom_vcnt",  32'(vcnt - v0), 32'd3);
      chk("nom_ecnt",  32'(ecnt - e0), 32'd0);
      chk("nom_capl",  32'(cap_l),     32'hA5C3);
      chk("nom_capr",  32'(cap_r),     32'h1234);
      chk("nom_left",  32'(left),      32'hA5C3);

      // 24-bit slots truncated to the MSBs
      mark();
      slot(1'b0, {24'h89ABCD, 8'h0}, 1, 24);
      slot(1'b1, {24'h13579B, 8'h0}, 0, 24);
      slot(1'b0, {16'h0F0F, 16'h0}, 0, 1);
      #50;
      chk("trn_vcnt",  32'(vcnt - v0), 32'd1);
      chk("trn_capl",  32'(cap_l),     32'h89AB);
      chk("trn_capr",  32'(cap_r),     32'h1357);

      // 12-bit right slot is short
      mark();
      slot(1'b0, {16'h0F0F, 16'h0}, 1, 32);
      slot(1'b1, 32'hFFF0_0000, 0, 12);
      slot(1'b0, {16'h1111, 16'h0}, 0, 1);
      #50;
      chk("sht_ecnt",  32'(ecnt - e0), 32'd1);
      chk("sht_vcnt",  32'(vcnt - v0), 32'd0);
      chk("sht_left",  32'(left),      32'h89AB);
      chk("sht_right", 32'(right),     32'h1357);

      // resume right away; right slot exactly 16 bits is complete
      mark();
      slot(1'b0, {16'h1111, 16'h0}, 1, 32);
      slot(1'b1, {16'h2222, 16'h0}, 0, 16);
      slot(1'b0, {16'h3333, 16'h0}, 0, 1);
      #50;
      chk("res_vcnt",  32'(vcnt - v0), 32'd1);
      chk("res_capl",  32'(cap_l),     32'h1111);
      chk("res_capr",  32'(cap_r),     32'h2222);
      chk("res_ecnt",  32'(ecnt - e0), 32'd0);

      // bclk stops mid-left-slot
      mark();
      slot(1'b0, {16'h3333, 16'h0}, 1, 10);
      #(1000 * 10);
      chk("to_early",  32'(ecnt - e0), 32'd0);
      #(100 * 10);
      chk("to_ecnt",   32'(ecnt - e0), 32'd1);
      slot(1'b0, {16'h3333, 16'h0}, 10, 32);
      slot(1'b1, {16'h4444, 16'h0}, 0, 32);
      slot(1'b0, {16'h5555, 16'h0}, 0, 32);
      slot(1'b1, {16'h6666, 16'h0}, 0, 32);
      slot(1'b0, {16'h7777, 16'h0}, 0, 1);
      #50;
      chk("to_vcnt",   32'(vcnt - v0), 32'd1);
      chk("to_capl",   32'(cap_l),     32'h5555);
      chk("to_capr",   32'(cap_r),     32'h6666);
      chk("to_ecnt2",  32'(ecnt - e0), 32'd1);

      // one-cycle reset in the middle of a right slot
      mark();
      slot(1'b0, {16'h7777, 16'h0}, 1, 32);
      slot(1'b1, {16'h8888, 16'h0}, 0, 10);
      @(negedge clk) rst = 1'b1;
      @(negedge clk) rst = 1'b0;
      chk("mrst_left",  32'(left),  32'h0);
      chk("mrst_right", 32'(right), 32'h0);
      chk("mrst_valid", 32'(valid), 32'h0);
      slot(1'b1, {16'h8888, 16'h0}, 10, 32);
      slot(1'b0, {16'h7FFF, 16'h0}, 0, 1);
      #50;
      chk("mrst_vcnt",  32'(vcnt - v0), 32'd0);

      // full-scale values
      mark();
      slot(1'b0, {16'h7FFF, 16'h0}, 1, 32);
      slot(1'b1, {16'h8000, 16'h0}, 0, 32);
      slot(1'b0, 32'h0, 0, 1);
      #50;
      chk("fs_vcnt",   32'(vcnt - v0), 32'd1);
      chk("fs_left",   32'(left),      32'h7FFF);
      chk("fs_right",  32'(right),     32'h8000);

      chk("no_overlap", 32'(both), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
